ft2232_fifo_test_responder: RTL

FPGA-side master for the FT2232H synchronous 245 FIFO interface. It reads the host test stream: one START command, then N DATA packets carrying an incrementing byte pattern, then STOP. It checks each payload byte against the expected pattern and returns a 4-byte CMD_TEST_STOPPED report to the host. It sits between the FT2232 pins and the test-status logic in the FPGA top level.

---
 rtl/ft2232_fifo_test_responder.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ft2232_fifo_test_responder.sv
// FT2232H synchronous-245 FIFO master: parses START/DATA/STOP test stream, checks the payload pattern and returns a 4-byte report.
// Optional FIFO_LOOPBACK_EN: each DATA packet is echoed back to the host through a 64x8 buffer.

`ifndef CMD_TEST_START
`define CMD_TEST_START 2'b01
`endif
`ifndef CMD_TEST_DATA
`define CMD_TEST_DATA 2'b10
`endif
`ifndef CMD_TEST_STOP
`define CMD_TEST_STOP 2'b11
`endif
`ifndef CMD_TEST_STOPPED
`define CMD_TEST_STOPPED 2'b00
`endif
`ifndef TEST_ERROR_NONE
`define TEST_ERROR_NONE 8'h00
`endif
`ifndef TEST_ERROR_DATA_MISMATCH
`define TEST_ERROR_DATA_MISMATCH 8'h01
`endif
`ifndef TEST_ERROR_UNEXPECTED_CMD
`define TEST_ERROR_UNEXPECTED_CMD 8'h02
`endif

module ft2232_fifo_test_responder #(
  parameter int TURNAROUND_CYCLES = 1,
  parameter int MAX_PAYLOAD       = 63
) (
  input  logic       fifo_clk_o,
  input  logic       ft2232_reset_n_i,
  input  logic       fifo_rxf_n_i,
  input  logic       fifo_txe_n_i,
  output logic       fifo_oe_n_o,
  output logic       fifo_rd_n_o,
  output logic       fifo_wr_n_o,
  output logic       fifo_siwu_o,
  inout  wire  [7:0] fifo_data_io,
  output logic       test_running_o,
  output logic [7:0] test_number_o,
  output logic [7:0] error_code_o,
  output logic       test_done_o
);

  typedef enum logic [2:0] {IDLE, RD_OE, RD, TURN, WR, DONE} state_t;
  typedef enum logic [1:0] {P_CMD, P_START, P_DATA} pstate_t;

  localparam logic [1:0] TURN_LAST = 2'(TURNAROUND_CYCLES - 1);
`ifdef FIFO_LOOPBACK_EN
  localparam int IDX_W = 6;
`else
  localparam int IDX_W = 2;
`endif

  state_t           state_reg;
  pstate_t          pstate_reg;
  logic             oe_n_reg, rd_n_reg, wr_n_reg;
  logic             turn_to_wr_reg, report_pending_reg, running_reg, done_reg;
  logic [1:0]       turn_cnt_reg;
  logic [IDX_W-1:0] tx_idx_reg, tx_last;
  logic [5:0]       remaining_reg;
  logic [7:0]       expected_reg, tnum_reg, err_reg, rx_cap_reg, exp_cap_reg;
  logic [63:0]      payload_ok;
  logic [7:0]       rx_byte, report_byte, tx_data;
  logic [1:0]       rx_code;
  logic [5:0]       rx_cnt;
  logic             rd_fire, wr_fire, cmd_error, cmd_stop_ok, data_last;
  logic             exit_report, echo_start, wr_is_echo;

`ifdef FIFO_LOOPBACK_EN
  logic             tx_echo_reg;
  logic [5:0]       echo_len_reg, wr_ptr_reg, ram_raddr;
  logic [7:0]       echo_mem [64];
  logic [7:0]       ram_q_reg;
`endif

  // Lookup of legal DATA payload counts so MAX_PAYLOAD below 63 rejects longer packets.
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_payload_ok
      assign payload_ok[gi] = (gi <= MAX_PAYLOAD);
    end
  endgenerate

  always_comb begin
    rx_byte     = fifo_data_io;
    rx_code     = rx_byte[7:6];
    rx_cnt      = rx_byte[5:0];
    rd_fire     = (state_reg == RD) && !rd_n_reg && !fifo_rxf_n_i;
    wr_fire     = (state_reg == WR) && !wr_n_reg && !fifo_txe_n_i;
    cmd_stop_ok = (rx_code == `CMD_TEST_STOP) && running_reg && (rx_cnt == 6'd0);
    if (rx_code == `CMD_TEST_START)
      cmd_error = (rx_cnt != 6'd1);
    else if (rx_code == `CMD_TEST_DATA)
      cmd_error = !running_reg || !payload_ok[rx_cnt];
    else if (rx_code == `CMD_TEST_STOP)
      cmd_error = !cmd_stop_ok;
    else
      cmd_error = 1'b1;
    data_last   = (pstate_reg == P_DATA) && (remaining_reg == 6'd1);
    exit_report = rd_fire && (pstate_reg == P_CMD) && (cmd_error || cmd_stop_ok);
    case (tx_idx_reg[1:0])
      2'd0:    report_byte = {`CMD_TEST_STOPPED, 6'd3};
      2'd1:    report_byte = err_reg;
      2'd2:    report_byte = rx_cap_reg;
      default: report_byte = exp_cap_reg;
    endcase
`ifdef FIFO_LOOPBACK_EN
    echo_start = rd_fire && data_last;
    wr_is_echo = tx_echo_reg;
    tx_last    = tx_echo_reg ? echo_len_reg : 6'd3;
    if (!tx_echo_reg)
      tx_data = report_byte;
    else if (tx_idx_reg == 6'd0)
      tx_data = {`CMD_TEST_DATA, echo_len_reg};
    else
      tx_data = ram_q_reg;
    // Read address runs one ahead on each accepted byte so ram_q_reg already holds byte k-1 at index k.
    ram_raddr  = tx_idx_reg - 6'd1 + {5'd0, wr_fire};
`else
    echo_start = 1'b0;
    wr_is_echo = 1'b0;
    tx_last    = 2'd3;
    tx_data    = report_byte;
`endif
  end

`ifdef FIFO_LOOPBACK_EN
  always_ff @(posedge fifo_clk_o) begin
    if (rd_fire && (pstate_reg == P_DATA))
      echo_mem[wr_ptr_reg] <= rx_byte;
    ram_q_reg <= echo_mem[ram_raddr];
  end
`endif

  always_ff @(posedge fifo_clk_o or negedge ft2232_reset_n_i) begin
    if (!ft2232_reset_n_i) begin
      state_reg          <= IDLE;
      pstate_reg         <= P_CMD;
      oe_n_reg           <= 1'b1;
      rd_n_reg           <= 1'b1;
      wr_n_reg           <= 1'b1;
      turn_to_wr_reg     <= 1'b0;
      report_pending_reg <= 1'b0;
      running_reg        <= 1'b0;
      done_reg           <= 1'b0;
      turn_cnt_reg       <= 2'd0;
      tx_idx_reg         <= '0;
      remaining_reg      <= 6'd0;
      expected_reg       <= 8'd0;
      tnum_reg           <= 8'd0;
      err_reg            <= `TEST_ERROR_NONE;
      rx_cap_reg         <= 8'd0;
      exp_cap_reg        <= 8'd0;
`ifdef FIFO_LOOPBACK_EN
      tx_echo_reg        <= 1'b0;
      echo_len_reg       <= 6'd0;
      wr_ptr_reg         <= 6'd0;
`endif
    end else begin
      done_reg <= 1'b0;

      if (rd_fire) begin
        case (pstate_reg)
          P_CMD: begin
            if (cmd_error) begin
              err_reg            <= `TEST_ERROR_UNEXPECTED_CMD;
              report_pending_reg <= 1'b1;
            end else if (rx_code == `CMD_TEST_START) begin
              pstate_reg <= P_START;
            end else if (rx_code == `CMD_TEST_DATA) begin
              if (rx_cnt != 6'd0) begin
                pstate_reg    <= P_DATA;
                remaining_reg <= rx_cnt;
`ifdef FIFO_LOOPBACK_EN
                echo_len_reg  <= rx_cnt;
                wr_ptr_reg    <= 6'd0;
`endif
              end
            end else begin
              report_pending_reg <= 1'b1;
            end
          end
          P_START: begin
            tnum_reg     <= rx_byte;
            expected_reg <= 8'd0;
            err_reg      <= `TEST_ERROR_NONE;
            rx_cap_reg   <= 8'd0;
            exp_cap_reg  <= 8'd0;
            running_reg  <= 1'b1;
            pstate_reg   <= P_CMD;
          end
          P_DATA: begin
            if ((rx_byte != expected_reg) && (err_reg == `TEST_ERROR_NONE)) begin
              err_reg     <= `TEST_ERROR_DATA_MISMATCH;
              rx_cap_reg  <= rx_byte;
              exp_cap_reg <= expected_reg;
            end
            expected_reg  <= expected_reg + 8'd1;
            remaining_reg <= remaining_reg - 6'd1;
`ifdef FIFO_LOOPBACK_EN
            wr_ptr_reg    <= wr_ptr_reg + 6'd1;
`endif
            if (data_last)
              pstate_reg <= P_CMD;
          end
          default: pstate_reg <= P_CMD;
        endcase
      end

      case (state_reg)
        IDLE: begin
          if (report_pending_reg) begin
            state_reg      <= TURN;
            turn_to_wr_reg <= 1'b1;
            turn_cnt_reg   <= 2'd0;
`ifdef FIFO_LOOPBACK_EN
            tx_echo_reg    <= 1'b0;
`endif
          end else if (!fifo_rxf_n_i) begin
            oe_n_reg  <= 1'b0;
            state_reg <= RD_OE;
          end
        end
        RD_OE: begin
          rd_n_reg  <= 1'b0;
          state_reg <= RD;
        end
        RD: begin
          if (fifo_rxf_n_i || exit_report) begin
            rd_n_reg  <= 1'b1;
            oe_n_reg  <= 1'b1;
            state_reg <= IDLE;
          end else if (echo_start) begin
            rd_n_reg       <= 1'b1;
            oe_n_reg       <= 1'b1;
            state_reg      <= TURN;
            turn_to_wr_reg <= 1'b1;
            turn_cnt_reg   <= 2'd0;
`ifdef FIFO_LOOPBACK_EN
            tx_echo_reg    <= 1'b1;
`endif
          end
        end
        TURN: begin
          oe_n_reg <= 1'b1;
          if (turn_cnt_reg == TURN_LAST) begin
            if (turn_to_wr_reg) begin
              state_reg  <= WR;
              wr_n_reg   <= 1'b0;
              tx_idx_reg <= '0;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            turn_cnt_reg <= turn_cnt_reg + 2'd1;
          end
        end
        WR: begin
          if (wr_fire) begin
            if (tx_idx_reg == tx_last) begin
              wr_n_reg       <= 1'b1;
              turn_to_wr_reg <= 1'b0;
              turn_cnt_reg   <= 2'd0;
              if (wr_is_echo) begin
                state_reg <= TURN;
              end else begin
                state_reg          <= DONE;
                done_reg           <= 1'b1;
                running_reg        <= 1'b0;
                report_pending_reg <= 1'b0;
              end
            end else begin
              tx_idx_reg <= tx_idx_reg + IDX_W'(1);
            end
          end
        end
        DONE: begin
          // Bus goes back to the FT2232 after a full turnaround before reading resumes.
          state_reg      <= TURN;
          turn_to_wr_reg <= 1'b0;
          turn_cnt_reg   <= 2'd0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign fifo_data_io   = (state_reg == WR) ? tx_data : 8'hzz;
  assign fifo_oe_n_o    = oe_n_reg;
  assign fifo_rd_n_o    = rd_n_reg;
  assign fifo_wr_n_o    = wr_n_reg;
  assign fifo_siwu_o    = 1'b1;
  assign test_running_o = running_reg;
  assign test_number_o  = tnum_reg;
  assign error_code_o   = err_reg;
  assign test_done_o    = done_reg;

endmodule
